// File: rtl/serial_add_pkg.sv
// Shared FSM encodings and default operand width for the bit-serial adder.
package serial_add_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder shared by the serial datapath.
module Full_Adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: LSB-first, one bit per clock through one full adder.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cmsb_q, cmsb_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic fa_s, fa_c;

    Full_Adder u_fa (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                // Counter saturates at WIDTH: that final RUN cycle only publishes the result.
                if (cnt_q == CntW'(WIDTH)) begin
                    state_d = StDone;
                    sum_d   = res_q;
                    cout_d  = carry_q;
                    ovf_d   = carry_q ^ cmsb_q;
                end else begin
                    opa_d   = opa_q >> 1;
                    opb_d   = opb_q >> 1;
                    res_d   = {fa_s, res_q[WIDTH-1:1]};
                    carry_d = fa_c;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        cmsb_d = carry_q;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule
